uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver: the next generation of the 8-bit receiver. It adds an input synchroniser, mid-bit sampling from a per-bit clock divider, and start-glitch rejection. It supports configurable data width, optional parity, one or two stop bits, a held valid/ready output handshake, and parity, framing and overrun error reporting. It sits between the board RX pin and the host command decoder that feeds the TPU.

## Interface
- CLKS_PER_BIT, 16 — clk cycles per UART bit; integer ≥ 4.
- DATA_BITS, 8 — data bits per frame; 5..9; sent LSB first.
- PARITY_EN, 0 — 1 means one parity bit follows the data.
- PARITY_ODD, 0 — 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1 — 1 or 2.

- clk  input  1  — single clock; all logic on its rising edge.
- rst_n  input  1  — reset, synchronous and active-low.
- rx  input  1  — asynchronous serial line; idle high.
- ready  input  1  — consumer accepts data this cycle when valid=1.
- valid  output  1  — data/parity_err/frame_err hold a received frame.
- data  output  DATA_BITS  — received word.
- parity_err  output  1  — parity mismatch in the frame in data; qualified by valid.
- frame_err  output  1  — a stop bit sampled 0 in the frame in data; qualified by valid.
- overrun  output  1  — one-cycle pulse: a completed frame was discarded.
- busy  output  1  — high in every state other than IDLE.

## Operation
- rx passes through a 2-FF synchroniser (both stages reset to 1); the FSM sees only the synchronised signal rxs.
- Counter cnt has width $clog2(CLKS_PER_BIT). Let H = CLKS_PER_BIT/2 (integer division) and N = DATA_BITS + PARITY_EN + STOP_BITS.
- IDLE: when rxs=0, go to START with cnt=0.
- START: cnt increments. At cnt=H-1, sample rxs:
  - rxs=0: go to DATA with cnt=0 and bit index=0.
  - rxs=1: glitch; go to IDLE with no output.
- DATA: at cnt=CLKS_PER_BIT-1, shift rxs into bit[index] and set cnt=0. After DATA_BITS samples, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: sample at cnt=CLKS_PER_BIT-1. Error when XOR(data, parity bit) ≠ PARITY_ODD.
- STOP: sample each stop bit at cnt=CLKS_PER_BIT-1. Any stop sample of 0 sets the frame's frame_err. On the final stop sample, deliver the frame:
  - frame_err=0: go to IDLE.
  - frame_err=1: go to BREAK_WAIT.
- BREAK_WAIT: stay until rxs=1, then go to IDLE. A line held low (break) therefore produces exactly one frame.
- Delivery when valid=0, or when valid=1 and ready=1 in the same cycle: load data, parity_err and frame_err; valid=1.
- Delivery when valid=1 and ready=0: discard the new frame; the old frame is kept; overrun=1 for one cycle.
- valid stays high until a cycle with ready=1. It clears on that edge unless a delivery occurs on the same edge.
- Output registers change only on delivery. data is stable while valid=1.

## Timing
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE, cnt=0, synchroniser=1.
  - valid=0, data=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame with no output. Afterwards, the first rxs=0 seen in IDLE starts a new frame.
- Define edge t as the edge where IDLE→START occurs, i.e. the first edge with rxs=0. rxs lags the pin by 2 edges.
  - Start bit is sampled at edge t+H.
  - Bit k (k=0..N-1, covering data, then parity, then stops) is sampled at edge t+H+(k+1)·CLKS_PER_BIT.
  - valid rises at edge t+H+N·CLKS_PER_BIT, i.e. about H cycles before the frame's nominal end.
- After a normal frame, the FSM is in IDLE during the second half of the last stop bit. Back-to-back frames with no idle gap are received.
- Handshake: transfer happens on an edge where valid=1 and ready=1. ready while valid=0 is ignored.
- overrun is never asserted together with a change of data.

## Test plan
- Reset and rx=1 for 200 cycles → valid=0, busy=0, overrun=0, data=0 throughout.
- Defaults (C=16, 8N1): send 0xA5 with ready=1 → one valid pulse, data=0xA5, both error flags 0, valid high exactly 1 cycle. Latency checked against t+8+9·16.
- PARITY_EN=1, PARITY_ODD=0: send 0x3C with parity bit 1 → parity_err=1. Then send 0x3C with parity bit 0 → parity_err=0.
- rx low for 5 cycles, then high (glitch) → START aborts to IDLE with no valid. Then a 0x0F frame → data=0x0F.
- Break: rx low for 40 bit-times → exactly one valid with data=0x00 and frame_err=1; no second frame until rx has returned high and a new start bit arrives.
- ready=0: send 0x11, then 0x22 → data=0x11 held and overrun pulses once. Then ready=1 → valid drops. Also, rst_n=0 mid-frame for 1 cycle → no valid for that frame.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling, start-glitch rejection, parity/framing/overrun flags.
// Latency: valid rises H + N*CLKS_PER_BIT edges after the first synchronised low, about half a bit before the frame ends.
// Backpressure: valid/data held until ready; a frame completing while the held one is unaccepted is dropped and overrun pulses.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic [1:0]           sync_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 rxs, tick, deliver;

    assign rxs  = sync_q[1];
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        deliver = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                        pe_d    = 1'b0;
                        fe_d    = 1'b0;
                    end
                end
            end
            DATA: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    sh_d = {rxs, sh_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    pe_d    = ((^sh_q) ^ rxs) != PODD;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    fe_d = fe_q | ~rxs;
                    if (bit_q == STOP_LAST) begin
                        deliver = 1'b1;
                        // a low stop bit may be a break: wait for the line to recover before re-arming
                        state_d = fe_d ? BREAK_WAIT : IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            sync_q  <= 2'b11;
            valid_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= 1'b0;
            if (deliver && (!valid_q || ready)) begin
                valid_q <= 1'b1;
                data_q  <= sh_q;
                perr_q  <= pe_d;
                ferr_q  <= fe_d;
            end else begin
                if (deliver) ovr_q <= 1'b1;
                if (valid_q && ready) valid_q <= 1'b0;
            end
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
endmodule
